// File: rtl/mul_div_result_catcher_if.sv
// Bus bundle for mul_div_result_catcher.
// Producer side: the issue strobe, the mul_div result word and flags, and the
// issue_ok back-pressure hint.
// Consumer side: a first-word-fall-through valid/ready result port.
// master = the environment (mul_div + consumer); slave = the catcher itself.
interface mul_div_result_catcher_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [WIDTH-1:0] R;
    logic             io_flag;
    logic             dz_flag;
    logic             of_flag;
    logic             uf_flag;
    logic             i_flag;
    logic             issue_ok;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_R;
    logic [4:0]       o_flags;

    modport master (
        output en, R, io_flag, dz_flag, of_flag, uf_flag, i_flag, o_ready,
        input  issue_ok, o_valid, o_R, o_flags
    );

    modport slave (
        input  en, R, io_flag, dz_flag, of_flag, uf_flag, i_flag, o_ready,
        output issue_ok, o_valid, o_R, o_flags
    );
endinterface

// File: rtl/mul_div_result_catcher.sv
// mul_div_result_catcher: follows every mul_div issue with a 1-bit token
// through a LATENCY-deep pipe and, when the token falls out of the pipe,
// captures {R, flags} into a small first-word-fall-through FIFO.
// issue_ok tells the issuer whether one more operation is guaranteed a slot.
// A capture that meets a full FIFO (with no same-cycle pop) is dropped and
// latches drop_err until clr_sticky.
// Optional macro STICKY_FLAGS_EN: when defined, sticky_flags OR-accumulates
// the flags of every accepted result; when undefined it is tied to zero.
module mul_div_result_catcher #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    arst,
    mul_div_result_catcher_if.slave bus,
    output logic                    drop_err,
    input  logic                    clr_sticky,
    output logic [4:0]              sticky_flags
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;
    localparam int EW = WIDTH + 5;

    logic [LATENCY-1:0] tok;
    logic               capture;
    logic [SW-1:0]      in_flight;
    logic [SW-1:0]      occupancy;

    logic [EW-1:0]      ram [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [EW-1:0]      head;

    logic [4:0]         in_flags;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    assign in_flags = {bus.io_flag, bus.dz_flag, bus.of_flag, bus.uf_flag, bus.i_flag};
    assign capture  = tok[LATENCY-1];

    // Token pipe: stage 0 samples en, the last stage marks the capture cycle.
    always_ff @(posedge clk) begin
        if (arst) begin
            tok <= '0;
        end else begin
            tok[0] <= bus.en;
            for (int i = 1; i < LATENCY; i++) begin
                tok[i] <= tok[i-1];
            end
        end
    end

    // Count tokens still travelling; the one in the last stage is this cycle's push.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            in_flight = in_flight + SW'(tok[i]);
        end
    end

    // Space guarantee uses registered state only; pops are not credited, so it is conservative.
    always_comb begin
        occupancy    = SW'(count) + in_flight;
        bus.issue_ok = (occupancy < SW'(DEPTH));
    end

    // FIFO control: a same-cycle pop frees the slot a capture into a full FIFO needs.
    always_comb begin
        full    = (count == CW'(DEPTH));
        pop     = (count != '0) && bus.o_ready;
        push_ok = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    // Result storage, cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
        end else if (push_ok) begin
            ram[wr_ptr] <= {bus.R, in_flags};
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head presentation straight from the read pointer; holds the stale slot when empty.
    always_comb begin
        head        = ram[rd_ptr];
        bus.o_valid = (count != '0);
        bus.o_R     = head[EW-1:5];
        bus.o_flags = head[4:0];
    end

    // Sticky drop indicator; clearing wins over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (arst) begin
            drop_err <= 1'b0;
        end else if (clr_sticky) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end
    end

`ifdef STICKY_FLAGS_EN
    logic [4:0] sticky_q;

    // Accumulate flags of accepted results; clearing wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (arst) begin
            sticky_q <= '0;
        end else if (clr_sticky) begin
            sticky_q <= '0;
        end else if (push_ok) begin
            sticky_q <= sticky_q | in_flags;
        end
    end

    assign sticky_flags = sticky_q;
`else
    assign sticky_flags = 5'b00000;
`endif

endmodule

// File: tb/tb_mul_div_result_catcher.sv
// Testbench for mul_div_result_catcher (default WIDTH=32, LATENCY=2, DEPTH=4).
// The bench plays the mul_div: each issued operation gets its R/flags driven
// LATENCY cycles later, and its expected value is queued on a scoreboard at
// issue time; every accepted pop is compared against the queue head.
// Build with +define+STICKY_FLAGS_EN to exercise the sticky flag accumulator.
module tb_mul_div_result_catcher;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;
    localparam int RING    = 16;

`ifdef STICKY_FLAGS_EN
    localparam logic [4:0] STICKY_EXP = 5'b01100;
`else
    localparam logic [4:0] STICKY_EXP = 5'b00000;
`endif

    logic             clk;
    logic             arst;
    logic             drop_err;
    logic             clr_sticky;
    logic [4:0]       sticky_flags;

    int               n_compared = 0;
    int               n_mismatched = 0;
    int               cyc = 0;

    logic [WIDTH+4:0] sb [$];
    logic             sched_v [RING];
    logic [WIDTH-1:0] sched_r [RING];
    logic [4:0]       sched_f [RING];

    mul_div_result_catcher_if #(.WIDTH(WIDTH)) bus ();

    mul_div_result_catcher #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .bus          (bus),
        .drop_err     (drop_err),
        .clr_sticky   (clr_sticky),
        .sticky_flags (sticky_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic driveFlags(input logic [4:0] f);
        bus.io_flag = f[4];
        bus.dz_flag = f[3];
        bus.of_flag = f[2];
        bus.uf_flag = f[1];
        bus.i_flag  = f[0];
    endtask

    // One cycle: called at a negedge, drives this cycle's inputs, checks any pop, waits a cycle.
    task automatic applyStimulus(input logic en_i, input logic ready_i, input logic clr_i,
                                 input logic keep, input logic [WIDTH-1:0] r_i, input logic [4:0] f_i);
        int slot;
        int tgt;
        logic [WIDTH+4:0] exp;
        slot = cyc % RING;
        tgt  = (cyc + LATENCY) % RING;
        if (sched_v[slot]) begin
            bus.R = sched_r[slot];
            driveFlags(sched_f[slot]);
            sched_v[slot] = 1'b0;
        end else begin
            bus.R = $urandom;
            driveFlags(5'($urandom));
        end
        bus.en      = en_i;
        bus.o_ready = ready_i;
        clr_sticky  = clr_i;
        if (en_i) begin
            sched_v[tgt] = 1'b1;
            sched_r[tgt] = r_i;
            sched_f[tgt] = f_i;
            if (keep) sb.push_back({r_i, f_i});
        end
        if (bus.o_valid && ready_i) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_o_valid", 64'(bus.o_valid), 64'd0);
            end else begin
                exp = sb.pop_front();
                checkOutput("o_R", 64'(bus.o_R), 64'(exp[WIDTH+4:5]));
                checkOutput("o_flags", 64'(bus.o_flags), 64'(exp[4:0]));
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ready_i);
        applyStimulus(1'b0, ready_i, 1'b0, 1'b0, '0, 5'b00000);
    endtask

    // Holds reset for n cycles with en high (it must be ignored) and forgets all expectations.
    task automatic resetDut(input int n);
        arst        = 1'b1;
        bus.en      = 1'b1;
        bus.o_ready = 1'b0;
        clr_sticky  = 1'b0;
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
        arst   = 1'b0;
        bus.en = 1'b0;
        sb.delete();
        for (int i = 0; i < RING; i++) sched_v[i] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            idle(1'b1);
            guard++;
        end
        checkOutput({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
        checkOutput({tag, "_o_valid"}, 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        logic go;
        bus.R = '0;
        driveFlags(5'b00000);
        bus.o_ready = 1'b0;
        for (int i = 0; i < RING; i++) sched_v[i] = 1'b0;

        // Reset state
        resetDut(2);
        checkOutput("rst_o_valid", 64'(bus.o_valid), 64'd0);
        checkOutput("rst_issue_ok", 64'(bus.issue_ok), 64'd1);
        checkOutput("rst_o_R", 64'(bus.o_R), 64'd0);
        checkOutput("rst_o_flags", 64'(bus.o_flags), 64'd0);
        checkOutput("rst_drop_err", 64'(drop_err), 64'd0);
        checkOutput("rst_sticky", 64'(sticky_flags), 64'd0);

        // Single result latency
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h3F800000, 5'b00000);
        checkOutput("lat_valid_c1", 64'(bus.o_valid), 64'd0);
        idle(1'b0);
        checkOutput("lat_valid_c2", 64'(bus.o_valid), 64'd0);
        idle(1'b0);
        checkOutput("lat_valid_c3", 64'(bus.o_valid), 64'd1);
        checkOutput("lat_o_R", 64'(bus.o_R), 64'h3F800000);
        checkOutput("lat_o_flags", 64'(bus.o_flags), 64'd0);
        idle(1'b1);
        checkOutput("lat_empty", 64'(bus.o_valid), 64'd0);

        // Fill to DEPTH with the consumer stalled
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("fill_issue_ok", 64'(bus.issue_ok), 64'd1);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, $urandom, 5'($urandom));
        end
        checkOutput("full_issue_ok_c4", 64'(bus.issue_ok), 64'd0);
        idle(1'b0);
        idle(1'b0);
        checkOutput("full_o_valid", 64'(bus.o_valid), 64'd1);
        checkOutput("full_issue_ok", 64'(bus.issue_ok), 64'd0);
        checkOutput("full_no_drop", 64'(drop_err), 64'd0);

        // Fifth issue into a full FIFO is dropped
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'b10000);
        checkOutput("drop_pre1", 64'(drop_err), 64'd0);
        idle(1'b0);
        checkOutput("drop_pre2", 64'(drop_err), 64'd0);
        idle(1'b0);
        checkOutput("drop_err_set", 64'(drop_err), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 5'b00000);
        checkOutput("drop_err_clr", 64'(drop_err), 64'd0);

        // Capture and pop in the same cycle while full
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 5'b00001);
        idle(1'b0);
        idle(1'b1);
        checkOutput("pp_no_drop", 64'(drop_err), 64'd0);
        checkOutput("pp_o_valid", 64'(bus.o_valid), 64'd1);
        checkOutput("pp_issue_ok", 64'(bus.issue_ok), 64'd0);
        drain("pp_drain");

        // Sticky flags accumulate and clear
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 5'b00000);
        checkOutput("sticky_clr0", 64'(sticky_flags), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h40000000, 5'b00100);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h7F800000, 5'b01000);
        repeat (4) idle(1'b1);
        checkOutput("sticky_acc", 64'(sticky_flags), 64'(STICKY_EXP));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000001, 5'b00001);
        idle(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 5'b00000);
        checkOutput("sticky_clr_wins", 64'(sticky_flags), 64'd0);
        drain("sticky_drain");

        // Reset with two operations in flight
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hAAAA5555, 5'b00010);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h5555AAAA, 5'b00011);
        resetDut(1);
        checkOutput("mid_rst_o_valid", 64'(bus.o_valid), 64'd0);
        checkOutput("mid_rst_issue_ok", 64'(bus.issue_ok), 64'd1);
        checkOutput("mid_rst_o_R", 64'(bus.o_R), 64'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            checkOutput("post_rst_o_valid", 64'(bus.o_valid), 64'd0);
        end

        // Random issue gated by issue_ok, random consumer back-pressure
        for (int k = 0; k < 10000; k++) begin
            go = bus.issue_ok && ($urandom_range(0, 3) != 0);
            applyStimulus(go, 1'($urandom_range(0, 1)), 1'b0, 1'b1, $urandom, 5'($urandom));
        end
        checkOutput("rand_no_drop", 64'(drop_err), 64'd0);
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
